// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if
// Bundles the dbus request/response signals between the core's memory
// stage (master) and the data memory target (slave).
//   req_valid    request valid, held by the core until data_ok
//   req_addr     64-bit byte address
//   req_size     access size code (0=1B, 1=2B, 2=4B, 3=8B), informational
//   req_strobe   byte-lane write enables, zero means read
//   req_data     lane-aligned write data
//   resp_addr_ok address accepted, pulses together with resp_data_ok
//   resp_data_ok response valid, one cycle wide
//   resp_data    full aligned 64-bit read word (zero for writes)
interface dbus_sram_responder_if;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data
  );
endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder
// Data-bus memory target: accepts one request at a time, holds it for a
// programmable latency, then returns a single-cycle addr_ok/data_ok response.
// Byte-strobed writes land in a 64-bit wide internal array on the edge that
// ends the response cycle, so a read sees the pre-write word.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (array contents are kept)
//   bus    dbus_sram_responder_if.slave request/response bundle
// Parameters:
//   DEPTH      number of 64-bit words (power of two)
//   BASE_ADDR  byte address of word 0
//   LATENCY    cycles from request sample to response, 1..15
// Build option:
//   DBUS_RAND_LATENCY_EN  when defined, each request draws its latency from
//                         a 16-bit LFSR in the range 1..LATENCY.
//
// state | meaning
// IDLE  | waiting for req_valid; samples and latches the request
// WAIT  | counting down the access latency; aborts if req_valid drops
// RESP  | addr_ok/data_ok high for one cycle; write commits on exit
module dbus_sram_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_sram_responder_if.slave  bus
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  lat_load;
  logic        take;

  logic [63:0] lat_addr_q;
  logic [7:0]  lat_strobe_q;
  logic [63:0] lat_data_q;

  logic [63:0] sel_addr;
  logic [7:0]  sel_strobe;
  logic [63:0] off;
  logic        in_range;
  logic [IDX_W-1:0] idx;
  logic [63:0] rd_word;

  logic [63:0] mem [DEPTH];

`ifdef DBUS_RAND_LATENCY_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  // Loaded value is effective latency minus one.
  assign lat_load = 4'(32'(lfsr_q[3:0]) % LATENCY);
`else
  assign lat_load = 4'(LATENCY - 1);
`endif

  // When a request is taken straight into RESP (latency 1) the latched copy
  // is not yet valid, so decode from the live bus fields on that edge.
  assign sel_addr   = take ? bus.req_addr   : lat_addr_q;
  assign sel_strobe = take ? bus.req_strobe : lat_strobe_q;
  assign off        = sel_addr - BASE_ADDR;
  assign in_range   = (sel_addr >= BASE_ADDR) && (sel_addr < END_ADDR);
  assign idx        = off[IDX_W+2:3];
  assign rd_word    = (in_range && sel_strobe == 8'd0) ? mem[idx] : 64'd0;

  logic unused_ok;
  assign unused_ok = ^{bus.req_size, off[63:IDX_W+3], off[2:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          take    = 1'b1;
          cnt_d   = lat_load;
          state_d = (lat_load == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!bus.req_valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          // Terminal count: this decrement reaches zero.
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      lat_addr_q       <= 64'd0;
      lat_strobe_q     <= 8'd0;
      lat_data_q       <= 64'd0;
      bus.resp_addr_ok <= 1'b0;
      bus.resp_data_ok <= 1'b0;
      bus.resp_data    <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        lat_addr_q   <= bus.req_addr;
        lat_strobe_q <= bus.req_strobe;
        lat_data_q   <= bus.req_data;
      end
      bus.resp_addr_ok <= (state_d == RESP);
      bus.resp_data_ok <= (state_d == RESP);
      bus.resp_data    <= (state_d == RESP) ? rd_word : 64'd0;
    end
  end

  // Write commits on the edge leaving RESP; in RESP the decode uses the
  // latched request.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && lat_strobe_q != 8'd0 && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (lat_strobe_q[i]) mem[idx][8*i +: 8] <= lat_data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
`timescale 1ns/1ps
module tb_dbus_sram_responder;

`ifdef DBUS_RAND_LATENCY_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbus_sram_responder_if dbus();

  dbus_sram_responder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dbus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] lat_mask = 16'd0;

  // Byte-addressed reference memory.
  byte unsigned ref_mem [longint];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit ref_in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 8);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] w = 64'd0;
    longint base_b = longint'(a & ~64'd7);
    if (!ref_in_range(a)) return 64'd0;
    for (int i = 0; i < 8; i++)
      if (ref_mem.exists(base_b + i)) w[8*i +: 8] = ref_mem[base_b + i];
    return w;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    longint base_b = longint'(a & ~64'd7);
    if (!ref_in_range(a)) return;
    for (int i = 0; i < 8; i++)
      if (s[i]) ref_mem[base_b + i] = d[8*i +: 8];
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    dbus.req_valid  = v;
    dbus.req_addr   = a;
    dbus.req_size   = 3'd3;
    dbus.req_strobe = s;
    dbus.req_data   = d;
  endtask

  // Full transaction; called between edges with the DUT idle.
  task automatic run_req(input string tag, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    logic [63:0] exp;
    int lat;
    exp = (s == 8'd0) ? ref_read(a) : 64'd0;
    drive(1'b1, a, s, d);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      // Scramble the held fields; the latched copy must be used.
      if (k == 1) begin
        dbus.req_data  = ~d;
        dbus.req_addr  = a ^ 64'h8;
      end
      if (dbus.resp_data_ok) begin lat = k; break; end
    end
    if (lat == 0) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      drive(1'b0, 64'd0, 8'd0, 64'd0);
      return;
    end
    lat_mask[lat] = 1'b1;
`ifdef DBUS_RAND_LATENCY_EN
    chk({tag, "_lat_range"}, 64'((lat >= 1) && (lat <= LAT)), 64'd1);
`else
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
`endif
    chk({tag, "_addr_ok"}, 64'(dbus.resp_addr_ok), 64'd1);
    chk({tag, "_data"}, dbus.resp_data, exp);
    drive(1'b0, 64'd0, 8'd0, 64'd0);
    ref_write(a, s, d);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 64'({dbus.resp_addr_ok, dbus.resp_data_ok}), 64'd0);
  endtask

  initial begin
    logic [63:0] a, d;
    logic [7:0]  s;
    int ones;

    reset = 1'b1;
    drive(1'b0, 64'd0, 8'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_ok", 64'(dbus.resp_addr_ok), 64'd0);
    chk("rst_data_ok", 64'(dbus.resp_data_ok), 64'd0);
    chk("rst_data", dbus.resp_data, 64'd0);
    reset = 1'b0;

    run_req("wr_full", 64'h8000_0008, 8'hFF, 64'h1122334455667788);
    run_req("rd_full", 64'h8000_0008, 8'h00, 64'd0);
    chk("rd_full_const", ref_read(64'h8000_0008), 64'h1122334455667788);
    run_req("wr_byte", 64'h8000_000B, 8'h08, 64'h0000_0000_AA00_0000);
    run_req("rd_byte", 64'h8000_0008, 8'h00, 64'd0);
    chk("rd_byte_const", ref_read(64'h8000_0008), 64'h11223344AA667788);
    run_req("wr_oor", 64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_req("rd_oor", 64'h7FFF_FFF8, 8'h00, 64'd0);
    run_req("rd_oor_hi", BASE + 64'(DEPTH) * 8, 8'h00, 64'd0);
    run_req("rd_after_oor", 64'h8000_0008, 8'h00, 64'd0);
    run_req("wr_w2", 64'h8000_0010, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF);

`ifndef DBUS_RAND_LATENCY_EN
    begin
      bit seen = 1'b0;
      drive(1'b1, 64'h8000_0008, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
      @(posedge clk); #1;
      dbus.req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (dbus.resp_data_ok || dbus.resp_addr_ok) seen = 1'b1;
      end
      chk("abort_no_ack", 64'(seen), 64'd0);
      run_req("rd_after_abort", 64'h8000_0008, 8'h00, 64'd0);

      drive(1'b1, 64'h8000_0010, 8'hFF, 64'h5555_5555_5555_5555);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_outs", 64'({dbus.resp_addr_ok, dbus.resp_data_ok}), 64'd0);
      chk("midrst_data", dbus.resp_data, 64'd0);
      reset = 1'b0;
      drive(1'b0, 64'd0, 8'd0, 64'd0);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (dbus.resp_data_ok) seen = 1'b1;
      end
      chk("midrst_no_ack", 64'(seen), 64'd0);
      run_req("rd_w2_after_rst", 64'h8000_0010, 8'h00, 64'd0);
      run_req("rd_w1_after_rst", 64'h8000_0008, 8'h00, 64'd0);
    end
`endif

    for (int i = 0; i < 16; i++)
      run_req("init", BASE + 64'(i) * 8, 8'hFF, {$urandom, $urandom});

    for (int n = 0; n < 48; n++) begin
      a = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0)
        a = ($urandom_range(0, 1) == 0) ? BASE - 64'($urandom_range(1, 64))
                                        : BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 64));
      s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      run_req((s == 8'h00) ? "rnd_rd" : "rnd_wr", a, s, d);
    end

    lat_mask = 16'd0;
    for (int n = 0; n < 64; n++)
      run_req("seq_rd", BASE + 64'($urandom_range(0, 15)) * 8, 8'h00, 64'd0);
    ones = $countones(lat_mask);
`ifdef DBUS_RAND_LATENCY_EN
    chk("distinct_lat", 64'(ones >= 2), 64'd1);
`else
    chk("distinct_lat", 64'(ones), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
